// File: rtl/cond_sum_adder_pipe.sv
// Pipelined conditional-sum adder: {C_out,S} = A + B + C_in with one register bank per merge level.
// Optional signed-overflow output Ovf is enabled by defining CSA_OVERFLOW_FLAG_EN.
module cond_sum_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             Out_valid,
  input  logic             Out_ready
`ifdef CSA_OVERFLOW_FLAG_EN
  ,
  output logic             Ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("cond_sum_adder_pipe: WIDTH must be a power of two in 4..64");
  end

  logic              advance;
  logic              accept;
  logic [LEVELS:0]   vld_q;
  logic [LEVELS:0]   cin_q;

  assign advance   = !vld_q[LEVELS] || Out_ready;
  assign accept    = In_valid && advance;
  assign In_ready  = advance;
  assign Out_valid = vld_q[LEVELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cin_q <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[LEVELS-1:0], accept};
      cin_q <= {cin_q[LEVELS-1:0], C_in};
    end
  end

  // Level k holds WIDTH>>k blocks, each with sum/carry candidates for carry-in 0 and 1.
  for (genvar k = 0; k <= LEVELS; k++) begin : lvl
    localparam int NB = WIDTH >> k;
    logic [WIDTH-1:0] s0, s1, s0_d, s1_d;
    logic [NB-1:0]    c0, c1, c0_d, c1_d;

    if (k == 0) begin : g_init
      always_comb begin
        s0_d = A ^ B;
        s1_d = ~(A ^ B);
        c0_d = A & B;
        c1_d = A | B;
      end
    end else begin : g_merge
      localparam int H = 1 << (k - 1);
      // Lower half passes through; upper half and block carry are chosen by the lower half's carries.
      always_comb begin
        s0_d = lvl[k-1].s0;
        s1_d = lvl[k-1].s1;
        c0_d = '0;
        c1_d = '0;
        for (int unsigned j = 0; j < NB; j++) begin
          for (int unsigned b = 0; b < H; b++) begin
            s0_d[2*j*H + H + b] = lvl[k-1].c0[2*j] ? lvl[k-1].s1[2*j*H + H + b]
                                                   : lvl[k-1].s0[2*j*H + H + b];
            s1_d[2*j*H + H + b] = lvl[k-1].c1[2*j] ? lvl[k-1].s1[2*j*H + H + b]
                                                   : lvl[k-1].s0[2*j*H + H + b];
          end
          c0_d[j] = lvl[k-1].c0[2*j] ? lvl[k-1].c1[2*j+1] : lvl[k-1].c0[2*j+1];
          c1_d[j] = lvl[k-1].c1[2*j] ? lvl[k-1].c1[2*j+1] : lvl[k-1].c0[2*j+1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s0 <= '0;
        s1 <= '0;
        c0 <= '0;
        c1 <= '0;
      end else if (advance) begin
        s0 <= s0_d;
        s1 <= s1_d;
        c0 <= c0_d;
        c1 <= c1_d;
      end
    end
  end

  assign S     = cin_q[LEVELS] ? lvl[LEVELS].s1    : lvl[LEVELS].s0;
  assign C_out = cin_q[LEVELS] ? lvl[LEVELS].c1[0] : lvl[LEVELS].c0[0];

`ifdef CSA_OVERFLOW_FLAG_EN
  // Carry into the MSB is recovered as S[msb] ^ A[msb] ^ B[msb]; only the propagate bit is carried.
  logic [LEVELS:0] p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
    end else if (advance) begin
      p_q <= {p_q[LEVELS-1:0], A[WIDTH-1] ^ B[WIDTH-1]};
    end
  end

  assign Ovf = S[WIDTH-1] ^ p_q[LEVELS] ^ C_out;
`endif

endmodule

// File: tb/tb_cond_sum_adder_pipe.sv
// Self-checking bench for cond_sum_adder_pipe: directed vectors on WIDTH=16, random regression on 4/16/64.
module tb_cond_sum_adder_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        ovf;
  } vec_t;

  localparam int NBEATS = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_r [3];
  logic [63:0] b_r [3];
  logic        cin_r [3];
  logic        iv_r [3];
  logic        or_r [3];
  logic        ir_w [3];
  logic        ov_w [3];
  logic        c_w [3];
  logic        ovf_w [3];
  logic [63:0] s_w [3];
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [63:0] s64;

  int errors = 0;
  int checks = 0;
  int unsigned wd [3] = '{4, 16, 64};

  always #5 clk = ~clk;

  assign s_w[0] = {60'd0, s4};
  assign s_w[1] = {48'd0, s16};
  assign s_w[2] = s64;

`ifndef CSA_OVERFLOW_FLAG_EN
  assign ovf_w[0] = 1'b0;
  assign ovf_w[1] = 1'b0;
  assign ovf_w[2] = 1'b0;
`endif

  cond_sum_adder_pipe #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .A(a_r[0][3:0]), .B(b_r[0][3:0]), .C_in(cin_r[0]),
    .In_valid(iv_r[0]), .In_ready(ir_w[0]), .S(s4), .C_out(c_w[0]),
    .Out_valid(ov_w[0]), .Out_ready(or_r[0])
`ifdef CSA_OVERFLOW_FLAG_EN
    , .Ovf(ovf_w[0])
`endif
  );

  cond_sum_adder_pipe #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .A(a_r[1][15:0]), .B(b_r[1][15:0]), .C_in(cin_r[1]),
    .In_valid(iv_r[1]), .In_ready(ir_w[1]), .S(s16), .C_out(c_w[1]),
    .Out_valid(ov_w[1]), .Out_ready(or_r[1])
`ifdef CSA_OVERFLOW_FLAG_EN
    , .Ovf(ovf_w[1])
`endif
  );

  cond_sum_adder_pipe #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst(rst), .A(a_r[2]), .B(b_r[2]), .C_in(cin_r[2]),
    .In_valid(iv_r[2]), .In_ready(ir_w[2]), .S(s64), .C_out(c_w[2]),
    .Out_valid(ov_w[2]), .Out_ready(or_r[2])
`ifdef CSA_OVERFLOW_FLAG_EN
    , .Ovf(ovf_w[2])
`endif
  );

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One isolated beat on the 16-bit DUT: Out_valid must appear exactly 5 samples after the accept edge.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    a_r[1] = 64'(v.a); b_r[1] = 64'(v.b); cin_r[1] = v.cin; iv_r[1] = 1'b1; or_r[1] = 1'b1;
    #1 chk("vec_in_ready", 65'(ir_w[1]), 65'(1));
    @(negedge clk);
    iv_r[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      #1 chk("vec_latency_valid", 65'(ov_w[1]), 65'(k == 5));
      if (k == 5) begin
        chk("vec_sum", 65'({c_w[1], s_w[1][15:0]}), 65'({v.c, v.s}));
`ifdef CSA_OVERFLOW_FLAG_EN
        chk("vec_ovf", 65'(ovf_w[1]), 65'(v.ovf));
`endif
      end
    end
  endtask

  vec_t        vecs [6];
  int          sent, recv, cyc;
  logic        stall, hold_c;
  logic [15:0] hold_s;
  logic [16:0] sexp;
  logic [64:0] fifo  [3][16];
  logic        ofifo [3][16];
  int          wr [3];
  int          rd [3];
  logic [63:0] m;
  logic [64:0] sum65, got65;
  logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      a_r[d] = '0; b_r[d] = '0; cin_r[d] = 1'b0; iv_r[d] = 1'b0; or_r[d] = 1'b1;
      wr[d] = 0; rd[d] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_out_valid", 65'(ov_w[d]), 65'(0));
      chk("reset_sum", 65'({c_w[d], s_w[d]}), 65'(0));
      chk("reset_in_ready", 65'(ir_w[d]), 65'(1));
      chk("reset_ovf", 65'(ovf_w[d]), 65'(0));
    end
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Streaming with Out_ready pattern 1,0,0,1.
    sent = 0; recv = 0; cyc = 0; stall = 1'b0; hold_s = '0; hold_c = 1'b0;
    while (recv < 8 && cyc < 200) begin
      @(negedge clk);
      or_r[1]  = pat[cyc % 4];
      iv_r[1]  = (sent < 8);
      a_r[1]   = 64'(sent);
      b_r[1]   = 64'(256 * sent);
      cin_r[1] = sent[0];
      #1;
      if (stall) chk("stall_hold", 65'({ov_w[1], c_w[1], s_w[1][15:0]}), 65'({1'b1, hold_c, hold_s}));
      chk("in_ready_rule", 65'(ir_w[1]), 65'(!(ov_w[1] && !or_r[1])));
      if (ov_w[1] && or_r[1]) begin
        sexp = 17'(recv) + 17'(256 * recv) + 17'(recv % 2);
        chk("stream_sum", 65'({c_w[1], s_w[1][15:0]}), 65'(sexp));
        recv++;
      end
      stall  = ov_w[1] && !or_r[1];
      hold_s = s_w[1][15:0];
      hold_c = c_w[1];
      if (iv_r[1] && ir_w[1]) sent++;
      cyc++;
    end
    chk("stream_count", 65'(recv), 65'(8));
    iv_r[1] = 1'b0; or_r[1] = 1'b1;

    // Reset while three beats are in flight; a beat offered during reset must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_r[1] = 64'(16'h1111 * (i + 1)); b_r[1] = 64'(16'h0F0F); cin_r[1] = 1'b1; iv_r[1] = 1'b1;
      #1 chk("midflight_in_ready", 65'(ir_w[1]), 65'(1));
    end
    @(negedge clk);
    rst = 1'b1; a_r[1] = 64'(16'hAAAA);
    @(negedge clk);
    rst = 1'b0; iv_r[1] = 1'b0;
    #1;
    chk("midreset_out_valid", 65'(ov_w[1]), 65'(0));
    chk("midreset_sum", 65'({c_w[1], s_w[1]}), 65'(0));
    chk("midreset_in_ready", 65'(ir_w[1]), 65'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 chk("no_ghost_output", 65'(ov_w[1]), 65'(0));
    end
    run_vec(vecs[1]);

    // Random regression on all three widths in lockstep.
    for (int d = 0; d < 3; d++) begin wr[d] = 0; rd[d] = 0; end
    cyc = 0;
    while ((rd[0] < NBEATS || rd[1] < NBEATS || rd[2] < NBEATS) && cyc < 40000) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        m = (wd[d] == 64) ? '1 : ((64'd1 << wd[d]) - 64'd1);
        iv_r[d]  = (wr[d] < NBEATS) && ($urandom_range(0, 9) < 7);
        or_r[d]  = ($urandom_range(0, 9) < 7);
        a_r[d]   = {$urandom, $urandom} & m;
        b_r[d]   = {$urandom, $urandom} & m;
        cin_r[d] = $urandom_range(0, 1) == 1;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        if (ov_w[d] && or_r[d]) begin
          got65 = (65'(c_w[d]) << wd[d]) | 65'(s_w[d]);
          chk("rand_sum", got65, fifo[d][rd[d] % 16]);
`ifdef CSA_OVERFLOW_FLAG_EN
          chk("rand_ovf", 65'(ovf_w[d]), 65'(ofifo[d][rd[d] % 16]));
`endif
          rd[d]++;
        end
        if (iv_r[d] && ir_w[d]) begin
          sum65 = {1'b0, a_r[d]} + {1'b0, b_r[d]} + 65'(cin_r[d]);
          fifo[d][wr[d] % 16]  = sum65;
          ofifo[d][wr[d] % 16] = (a_r[d][wd[d]-1] == b_r[d][wd[d]-1]) &&
                                 (sum65[wd[d]-1] != a_r[d][wd[d]-1]);
          wr[d]++;
        end
      end
      cyc++;
    end
    for (int d = 0; d < 3; d++) begin
      chk("rand_accept_count", 65'(wr[d]), 65'(NBEATS));
      chk("rand_output_count", 65'(rd[d]), 65'(NBEATS));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
